id_stage: RTL and testbench

Instruction-decode stage of the 16-bit MIPS pipeline. It sits directly upstream of the register file. Each cycle it:
- decodes the IF/ID instruction and drives the register-file read addresses;
- receives both read ports, bypassing the same-cycle writeback value;
- detects load-use hazards;
- registers the decoded controls and operands into the ID/EX pipeline register consumed by EX.

---
 rtl/id_stage.sv | 66 ++++++
 tb/tb_id_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: MIPS-16 decode stage with WB bypass, load-use hazard detection and ID/EX register.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  input  logic [15:0] id_pc,
  input  logic        flush,
  input  logic        hold,
  output logic [3:0]  rs_addr,
  output logic [3:0]  rt_addr,
  input  logic [15:0] rs_data,
  input  logic [15:0] rt_data,
  input  logic        wb_reg_write,
  input  logic [3:0]  wb_rd,
  input  logic [15:0] wb_data,
  output logic        stall_if,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_alu_src,
  output logic [2:0]  ex_alu_op,
  output logic [3:0]  ex_rd,
  output logic [3:0]  ex_rs,
  output logic [3:0]  ex_rt,
  output logic [15:0] ex_rs_data,
  output logic [15:0] ex_rt_data,
  output logic [15:0] ex_imm,
  output logic [15:0] ex_pc
);
  typedef struct packed {
    logic        v, rw, mr, mw, br, as;
    logic [2:0]  op;
    logic [3:0]  rd, rs, rt;
    logic [15:0] rsd, rtd, imm, pc;
  } ex_t;
  ex_t ex_q, ex_d, dec;
  logic [3:0] op, a, b, c;
  logic r_type, known, uses_rs, uses_rt, hazard;
  logic [15:0] rs_fwd, rt_fwd;
  assign {op, a, b, c} = id_instr;
  assign r_type = op >= 4'd1 && op <= 4'd5;
  assign known = id_valid && op <= 4'd9;
  assign uses_rs = op >= 4'd1 && op <= 4'd9;
  assign uses_rt = r_type || op == 4'd8 || op == 4'd9;
  assign rs_addr = b;
  assign rt_addr = (op == 4'd8 || op == 4'd9) ? a : c;
  // The register file writes on the same edge that captures ID/EX, so forward WB here
  assign rs_fwd = (wb_reg_write && wb_rd == rs_addr) ? wb_data : rs_data;
  assign rt_fwd = (wb_reg_write && wb_rd == rt_addr) ? wb_data : rt_data;
  assign hazard = id_valid && ex_q.v && ex_q.mr &&
                  ((uses_rs && ex_q.rd == rs_addr) || (uses_rt && ex_q.rd == rt_addr));
  assign stall_if = (hazard && !flush) || hold;
  always_comb begin
    dec = '{v: 1'b1, rw: r_type || op == 4'd6 || op == 4'd7, mr: op == 4'd7, mw: op == 4'd8,
            br: op == 4'd9, as: op >= 4'd6 && op <= 4'd8,
            op: r_type ? op[2:0] - 3'd1 : {2'b00, op == 4'd9},
            rd: a, rs: b, rt: rt_addr, rsd: rs_fwd, rtd: rt_fwd, imm: {{12{c[3]}}, c}, pc: id_pc};
    ex_d = flush ? '0 : hold ? ex_q : (hazard || !known) ? '0 : dec;
  end
  always_ff @(posedge clk) ex_q <= rst ? '0 : ex_d;
  assign {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_alu_op,
          ex_rd, ex_rs, ex_rt, ex_rs_data, ex_rt_data, ex_imm, ex_pc} = ex_q;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a behavioural decode model.
module tb_id_stage;
  typedef struct packed {
    logic        v, rw, mr, mw, br, as;
    logic [2:0]  op;
    logic [3:0]  rd, rs, rt;
    logic [15:0] rsd, rtd, imm, pc;
  } ex_t;
  logic clk = 1'b0, rst, id_valid, flush, hold, wb_reg_write, stall_if;
  logic [15:0] id_instr, id_pc, rs_data, rt_data, wb_data;
  logic [3:0] wb_rd, rs_addr, rt_addr;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src;
  logic [2:0] ex_alu_op;
  logic [3:0] ex_rd, ex_rs, ex_rt;
  logic [15:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
  logic [15:0] rf [16];
  ex_t act, exp_q = '0, snap;
  logic st_seen;
  int pass_cnt = 0, chk_cnt = 0;

  always #5 clk = ~clk;
  always_ff @(posedge clk) if (wb_reg_write) rf[wb_rd] <= wb_data;
  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];
  assign act = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_alu_op,
                ex_rd, ex_rs, ex_rt, ex_rs_data, ex_rt_data, ex_imm, ex_pc};

  id_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .flush(flush), .hold(hold), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .stall_if(stall_if), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc(ex_pc)
  );

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    chk_cnt++;
    if (a === e) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask

  function automatic logic [15:0] operand(input logic [3:0] r);
    return (wb_reg_write && wb_rd == r) ? wb_data : rf[r];
  endfunction

  function automatic ex_t model_dec(input logic v, input logic [15:0] ins, input logic [15:0] pc);
    ex_t d = '0;
    int op = int'(ins[15:12]);
    logic [3:0] a = ins[11:8], b = ins[7:4], c = ins[3:0];
    if (!v || op > 9) return d;
    d.v = 1; d.rd = a; d.rs = b; d.rt = (op == 8 || op == 9) ? a : c;
    d.rsd = operand(d.rs); d.rtd = operand(d.rt);
    d.imm = {{12{c[3]}}, c}; d.pc = pc;
    if (op >= 1 && op <= 5) begin d.rw = 1; d.op = 3'(op - 1); end
    if (op == 6) begin d.rw = 1; d.as = 1; end
    if (op == 7) begin d.rw = 1; d.as = 1; d.mr = 1; end
    if (op == 8) begin d.mw = 1; d.as = 1; end
    if (op == 9) begin d.br = 1; d.op = 3'd1; end
    return d;
  endfunction

  task automatic step(input logic r, input logic v, input logic [15:0] ins, input logic [15:0] pc,
                      input logic fl, input logic hd, input logic we, input logic [3:0] wd,
                      input logic [15:0] wdat);
    int op;
    logic urs, urt, hz, st;
    logic [3:0] rt_m;
    ex_t nxt;
    rst = r; id_valid = v; id_instr = ins; id_pc = pc; flush = fl; hold = hd;
    wb_reg_write = we; wb_rd = wd; wb_data = wdat;
    @(negedge clk);
    op = int'(ins[15:12]);
    urs = op >= 1 && op <= 9;
    urt = (op >= 1 && op <= 5) || op == 8 || op == 9;
    rt_m = (op == 8 || op == 9) ? ins[11:8] : ins[3:0];
    hz = v && exp_q.v && exp_q.mr && ((urs && exp_q.rd == ins[7:4]) || (urt && exp_q.rd == rt_m));
    st = (hz && !fl) || hd;
    if (!r) begin
      chk("rs_addr", rs_addr, ins[7:4]);
      if (urt) chk("rt_addr", rt_addr, rt_m);
      chk("stall_if", stall_if, st);
    end
    st_seen = stall_if;
    nxt = (r || fl) ? '0 : hd ? exp_q : hz ? '0 : model_dec(v, ins, pc);
    @(posedge clk);
    #1;
    exp_q = nxt;
    chk("ex_state", act, exp_q);
  endtask

  initial begin
    step(1, 1, 16'h7410, 16'h1111, 1, 1, 0, 0, 0);
    chk("reset_zero", act, 0);
    for (int i = 0; i < 16; i++) step(1, 1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1, 4'(i), 0);
    step(0, 0, 16'h0000, 0, 0, 0, 1, 4'd1, 16'd5);
    chk("reset_stall", st_seen, 0);
    step(0, 0, 16'h0000, 0, 0, 0, 1, 4'd2, 16'd7);
    step(0, 1, 16'h1312, 16'h0040, 0, 0, 0, 0, 0);
    chk("rtype_valid", ex_valid, 1);
    chk("rtype_aluop", ex_alu_op, 0);
    chk("rtype_rw", ex_reg_write, 1);
    chk("rtype_rd", ex_rd, 3);
    chk("rtype_rs_data", ex_rs_data, 16'd5);
    chk("rtype_rt_data", ex_rt_data, 16'd7);
    step(0, 0, 16'h0000, 0, 0, 0, 1, 4'd1, 16'd0);
    step(0, 1, 16'h1312, 16'h0042, 0, 0, 1, 4'd1, 16'h1234);
    chk("bypass_rs_data", ex_rs_data, 16'h1234);
    step(0, 1, 16'h7410, 16'h0044, 0, 0, 0, 0, 0);
    step(0, 1, 16'h1541, 16'h0046, 0, 0, 0, 0, 0);
    chk("lu_stall", st_seen, 1);
    chk("lu_bubble", ex_valid, 0);
    step(0, 1, 16'h1541, 16'h0046, 0, 0, 0, 0, 0);
    chk("lu_nostall", st_seen, 0);
    chk("lu_issue_valid", ex_valid, 1);
    chk("lu_issue_rs", ex_rs, 4);
    step(0, 1, 16'h621F, 16'h0048, 0, 0, 0, 0, 0);
    chk("addi_imm", ex_imm, 16'hFFFF);
    chk("addi_src", ex_alu_src, 1);
    chk("addi_aluop", ex_alu_op, 0);
    step(0, 1, 16'h7410, 16'h004A, 0, 0, 0, 0, 0);
    step(0, 1, 16'h1541, 16'h004C, 1, 0, 0, 0, 0);
    chk("flush_hz_stall", st_seen, 0);
    chk("flush_hz_bubble", ex_valid, 0);
    step(0, 1, 16'h1541, 16'h004C, 0, 0, 0, 0, 0);
    snap = act;
    step(0, 1, 16'h7410, 16'h004E, 0, 1, 0, 0, 0);
    chk("hold_stall", st_seen, 1);
    chk("hold_keep", act, snap);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op = ($urandom_range(0, 3) == 0) ? 4'd7 : 4'($urandom_range(0, 15));
      logic [3:0] c = $urandom_range(0, 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) != 0,
           {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), c}, 16'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
           4'($urandom_range(0, 4)), 16'($urandom));
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
